// File: rtl/rnl_pkg.sv
// Shared types and helpers for the ramp-no-leak neuron body.
package rnl_pkg;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        INTEGRATE = 2'd1,
        FIRE      = 2'd2,
        DONE      = 2'd3
    } state_t;

    // Largest weight code; this is also the output pulse width in cycles.
    function automatic int unsigned wmax(input int unsigned wres);
        return (32'd1 << wres) - 32'd1;
    endfunction

    // Unsigned add that clamps at max_val instead of wrapping.
    function automatic int unsigned sat_add(input int unsigned a,
                                            input int unsigned b,
                                            input int unsigned max_val);
        int unsigned s;
        s = a + b;
        return (s > max_val) ? max_val : s;
    endfunction

endpackage

// File: rtl/rnl_neuron_body_popcount.sv
// Combinational count of the active unary synapse outputs in one cycle.
module syn_popcount #(
    parameter  int NUM_SYNAPSE = 16,
    localparam int CW          = $clog2(NUM_SYNAPSE + 1)
) (
    input  logic [NUM_SYNAPSE-1:0] syn_in,
    output logic [CW-1:0]          count
);

    // Sum of the single-bit inputs; synthesis balances this into an adder tree.
    always_comb begin
        count = '0;
        for (int i = 0; i < NUM_SYNAPSE; i++) begin
            count = count + CW'(syn_in[i]);
        end
    end

endmodule

// File: rtl/rnl_neuron_body.sv
// Ramp-no-leak neuron body: integrates synapse responses over a gamma cycle,
// emits one WMAX-wide output spike at the threshold crossing and records its time.
module rnl_neuron_body
    import rnl_pkg::*;
#(
    parameter int WRES        = 3,
    parameter int NUM_SYNAPSE = 16,
    parameter int PRES        = 7,
    parameter int TRES        = 4
) (
    input  logic                   clk,
    input  logic                   rstb,
    input  logic                   grst,
    input  logic [NUM_SYNAPSE-1:0] syn_in,
    input  logic [PRES-1:0]        threshold,
    output logic                   out_spike,
    output logic                   spike_valid,
    output logic [TRES-1:0]        spike_time,
    output logic [PRES-1:0]        potential
);

    localparam int          CW      = $clog2(NUM_SYNAPSE + 1);
    localparam int unsigned POT_MAX = (32'd1 << PRES) - 32'd1;
    localparam logic [WRES-1:0] PULSE_LAST = WRES'(wmax(WRES) - 1);

    state_t            state_q, state_d;
    logic [PRES-1:0]   pot_q, pot_d;
    logic [TRES-1:0]   tcnt_q, tcnt_d;
    logic [WRES-1:0]   pcnt_q, pcnt_d;
    logic [TRES-1:0]   stime_q, stime_d;
    logic              spike_q, spike_d;
    logic              valid_q, valid_d;
    logic [CW-1:0]     pop;
    logic [PRES-1:0]   next_pot;

    syn_popcount #(.NUM_SYNAPSE(NUM_SYNAPSE)) u_popcount (
        .syn_in (syn_in),
        .count  (pop)
    );

    assign next_pot = PRES'(sat_add(32'(pot_q), 32'(pop), POT_MAX));

    // Next-state and next-value logic; grst overrides every state.
    always_comb begin
        // NOTE: every target gets a default first so no path can infer a latch.
        state_d = state_q;
        pot_d   = pot_q;
        tcnt_d  = tcnt_q;
        pcnt_d  = pcnt_q;
        stime_d = stime_q;
        spike_d = spike_q;
        valid_d = valid_q;

        if (grst) begin
            state_d = INTEGRATE;
            pot_d   = '0;
            tcnt_d  = '0;
            pcnt_d  = '0;
            stime_d = '0;
            spike_d = 1'b0;
            valid_d = 1'b0;
        end else begin
            case (state_q)
                INTEGRATE: begin
                    pot_d  = next_pot;
                    tcnt_d = (tcnt_q == {TRES{1'b1}}) ? tcnt_q : tcnt_q + 1'b1;
                    if (next_pot >= threshold) begin
                        state_d = FIRE;
                        spike_d = 1'b1;
                        valid_d = 1'b1;
                        stime_d = tcnt_q;
                        pcnt_d  = '0;
                    end
                end
                FIRE: begin
                    if (pcnt_q == PULSE_LAST) begin
                        state_d = DONE;
                        spike_d = 1'b0;
                    end else begin
                        pcnt_d = pcnt_q + 1'b1;
                    end
                end
                default: ;  // IDLE and DONE hold everything
            endcase
        end
    end

    // State and counter registers with asynchronous clear.
    always_ff @(posedge clk or negedge rstb) begin
        if (!rstb) begin
            state_q <= IDLE;
            pot_q   <= '0;
            tcnt_q  <= '0;
            pcnt_q  <= '0;
            stime_q <= '0;
            spike_q <= 1'b0;
            valid_q <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments so all registers update from pre-edge values.
            state_q <= state_d;
            pot_q   <= pot_d;
            tcnt_q  <= tcnt_d;
            pcnt_q  <= pcnt_d;
            stime_q <= stime_d;
            spike_q <= spike_d;
            valid_q <= valid_d;
        end
    end

    assign out_spike   = spike_q;
    assign spike_valid = valid_q;
    assign spike_time  = stime_q;
    assign potential   = pot_q;

endmodule

// File: tb/tb_rnl_neuron_body.sv
// Directed bench for rnl_neuron_body: a 4-synapse instance for the main
// scenarios and a 16-synapse, 4-bit-potential instance for saturation.
module tb_rnl_neuron_body;

    logic clk = 1'b0;
    logic rstb;

    logic        grst_a;
    logic [3:0]  syn_a;
    logic [6:0]  thr_a;
    logic        out_a, valid_a;
    logic [3:0]  st_a;
    logic [6:0]  pot_a;

    logic        grst_b;
    logic [15:0] syn_b;
    logic [3:0]  thr_b;
    logic        out_b, valid_b;
    logic [3:0]  st_b;
    logic [3:0]  pot_b;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    rnl_neuron_body #(.WRES(3), .NUM_SYNAPSE(4), .PRES(7), .TRES(4)) u_a (
        .clk(clk), .rstb(rstb), .grst(grst_a), .syn_in(syn_a), .threshold(thr_a),
        .out_spike(out_a), .spike_valid(valid_a), .spike_time(st_a), .potential(pot_a)
    );

    rnl_neuron_body #(.WRES(3), .NUM_SYNAPSE(16), .PRES(4), .TRES(4)) u_b (
        .clk(clk), .rstb(rstb), .grst(grst_b), .syn_in(syn_b), .threshold(thr_b),
        .out_spike(out_b), .spike_valid(valid_b), .spike_time(st_b), .potential(pot_b)
    );

    // Advance one clock; outputs are sampled 1 ns after the edge.
    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    // One-cycle grst on instance A with the given syn_in during that cycle.
    task automatic gamma_a(input logic [3:0] syn);
        grst_a = 1'b1;
        syn_a  = syn;
        cyc();
        grst_a = 1'b0;
    endtask

    task automatic test_reset();
        rstb = 1'b0;
        grst_a = 1'b0; syn_a = 4'hF; thr_a = 7'd0;
        grst_b = 1'b0; syn_b = 16'hFFFF; thr_b = 4'd0;
        #3;
        checks++;
        if ({out_a, valid_a, st_a, pot_a} !== 12'd0) begin
            errors++;
            $display("FAIL reset_a: got out=%0b valid=%0b st=%0d pot=%0d expected all 0", out_a, valid_a, st_a, pot_a);
        end
        checks++;
        if ({out_b, valid_b, st_b, pot_b} !== 10'd0) begin
            errors++;
            $display("FAIL reset_b: got out=%0b valid=%0b st=%0d pot=%0d expected all 0", out_b, valid_b, st_b, pot_b);
        end
        #4 rstb = 1'b1;
        // In IDLE syn_in is ignored until grst arrives.
        repeat (3) cyc();
        checks++;
        if (pot_a !== 7'd0 || out_a !== 1'b0) begin
            errors++;
            $display("FAIL idle_ignore: got pot=%0d out=%0b expected pot=0 out=0", pot_a, out_a);
        end
        syn_a = 4'h0; syn_b = 16'h0;
    endtask

    task automatic test_basic_fire();
        int hi;
        thr_a = 7'd6;
        gamma_a(4'b0000);
        cyc(); cyc();                       // time counter 0 and 1, no input
        syn_a = 4'b0011;
        cyc();
        checks++;
        if (pot_a !== 7'd2) begin errors++; $display("FAIL basic_pot2: got %0d expected 2", pot_a); end
        cyc();
        checks++;
        if (pot_a !== 7'd4 || out_a !== 1'b0) begin
            errors++; $display("FAIL basic_pot4: got pot=%0d out=%0b expected pot=4 out=0", pot_a, out_a);
        end
        cyc();
        checks++;
        if (pot_a !== 7'd6 || out_a !== 1'b1 || valid_a !== 1'b1 || st_a !== 4'd4) begin
            errors++;
            $display("FAIL basic_cross: got pot=%0d out=%0b valid=%0b st=%0d expected 6 1 1 4", pot_a, out_a, valid_a, st_a);
        end
        hi = 1;
        for (int i = 0; i < 12; i++) begin
            cyc();
            if (out_a) hi++;
        end
        checks++;
        if (hi !== 7) begin errors++; $display("FAIL basic_width: got %0d cycles expected 7", hi); end
        checks++;
        if (pot_a !== 7'd6 || out_a !== 1'b0 || valid_a !== 1'b1 || st_a !== 4'd4) begin
            errors++;
            $display("FAIL basic_done: got pot=%0d out=%0b valid=%0b st=%0d expected 6 0 1 4", pot_a, out_a, valid_a, st_a);
        end
        syn_a = 4'b0000;
    endtask

    task automatic test_no_fire();
        int hi;
        thr_a = 7'd25;
        gamma_a(4'b0000);
        syn_a = 4'b0001;
        hi = 0;
        for (int i = 0; i < 20; i++) begin
            cyc();
            if (out_a) hi++;
        end
        checks++;
        if (hi !== 0 || valid_a !== 1'b0 || pot_a !== 7'd20) begin
            errors++;
            $display("FAIL nofire: got high=%0d valid=%0b pot=%0d expected 0 0 20", hi, valid_a, pot_a);
        end
        // Late crossing at index 24 must report the saturated count 15.
        repeat (5) cyc();
        checks++;
        if (out_a !== 1'b1 || valid_a !== 1'b1 || st_a !== 4'd15 || pot_a !== 7'd25) begin
            errors++;
            $display("FAIL late_cross: got out=%0b valid=%0b st=%0d pot=%0d expected 1 1 15 25", out_a, valid_a, st_a, pot_a);
        end
        syn_a = 4'b0000;
        repeat (8) cyc();
    endtask

    task automatic test_grst_mid_fire();
        thr_a = 7'd3;
        gamma_a(4'b0000);
        syn_a = 4'b0011;
        cyc(); cyc();                       // pot 2, then 4 -> crossing at index 1
        checks++;
        if (out_a !== 1'b1 || st_a !== 4'd1) begin
            errors++; $display("FAIL mid_cross: got out=%0b st=%0d expected 1 1", out_a, st_a);
        end
        cyc(); cyc();                       // now in pulse cycle 3
        gamma_a(4'b0011);                   // syn_in in the grst cycle is ignored
        syn_a = 4'b0000;
        checks++;
        if (out_a !== 1'b0 || pot_a !== 7'd0 || valid_a !== 1'b0 || st_a !== 4'd0) begin
            errors++;
            $display("FAIL mid_grst: got out=%0b pot=%0d valid=%0b st=%0d expected all 0", out_a, pot_a, valid_a, st_a);
        end
        cyc(); cyc(); cyc();                // indices 0..2 idle input
        syn_a = 4'b1111;
        cyc();
        checks++;
        if (out_a !== 1'b1 || valid_a !== 1'b1 || st_a !== 4'd3 || pot_a !== 7'd4) begin
            errors++;
            $display("FAIL mid_refire: got out=%0b valid=%0b st=%0d pot=%0d expected 1 1 3 4", out_a, valid_a, st_a, pot_a);
        end
        syn_a = 4'b0000;
        repeat (8) cyc();
    endtask

    task automatic test_thr_zero();
        thr_a = 7'd0;
        gamma_a(4'b1111);
        syn_a = 4'b0000;
        checks++;
        if (pot_a !== 7'd0 || out_a !== 1'b0) begin
            errors++; $display("FAIL zero_grst: got pot=%0d out=%0b expected 0 0", pot_a, out_a);
        end
        cyc();
        checks++;
        if (out_a !== 1'b1 || valid_a !== 1'b1 || st_a !== 4'd0) begin
            errors++; $display("FAIL zero_fire: got out=%0b valid=%0b st=%0d expected 1 1 0", out_a, valid_a, st_a);
        end
        repeat (8) cyc();
    endtask

    task automatic test_saturation();
        int hi;
        thr_b = 4'd15;
        grst_b = 1'b1; syn_b = 16'h0000;
        cyc();
        grst_b = 1'b0; syn_b = 16'hFFFF;
        cyc();
        checks++;
        if (pot_b !== 4'd15 || out_b !== 1'b1 || st_b !== 4'd0) begin
            errors++; $display("FAIL sat_cross: got pot=%0d out=%0b st=%0d expected 15 1 0", pot_b, out_b, st_b);
        end
        hi = 1;
        for (int i = 0; i < 12; i++) begin
            cyc();
            if (out_b) hi++;
        end
        checks++;
        if (hi !== 7 || pot_b !== 4'd15 || out_b !== 1'b0 || valid_b !== 1'b1) begin
            errors++;
            $display("FAIL sat_done: got high=%0d pot=%0d out=%0b valid=%0b expected 7 15 0 1", hi, pot_b, out_b, valid_b);
        end
        syn_b = 16'h0000;
    endtask

    task automatic test_reset_mid_fire();
        thr_a = 7'd2;
        gamma_a(4'b0000);
        syn_a = 4'b0011;
        cyc();                              // crossing, pulse starts
        cyc();
        #2 rstb = 1'b0;
        #1;
        checks++;
        if (out_a !== 1'b0 || valid_a !== 1'b0 || pot_a !== 7'd0 || st_a !== 4'd0) begin
            errors++;
            $display("FAIL async_rst: got out=%0b valid=%0b pot=%0d st=%0d expected all 0", out_a, valid_a, pot_a, st_a);
        end
        #1 rstb = 1'b1;
        syn_a = 4'b1111;
        repeat (3) cyc();
        checks++;
        if (out_a !== 1'b0 || pot_a !== 7'd0 || valid_a !== 1'b0) begin
            errors++; $display("FAIL rst_idle: got out=%0b pot=%0d valid=%0b expected 0 0 0", out_a, pot_a, valid_a);
        end
        gamma_a(4'b1111);
        cyc();
        checks++;
        if (out_a !== 1'b1 || pot_a !== 7'd4 || st_a !== 4'd0) begin
            errors++; $display("FAIL rst_recover: got out=%0b pot=%0d st=%0d expected 1 4 0", out_a, pot_a, st_a);
        end
        syn_a = 4'b0000;
        repeat (8) cyc();
    endtask

    initial begin
        test_reset();
        test_basic_fire();
        test_no_fire();
        test_grst_mid_fire();
        test_thr_zero();
        test_saturation();
        test_reset_mid_fire();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
